// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: owns the EX/MEM and MEM/WB registers, runs the data-memory req/ack
// transaction (sub-word lanes, sign/zero extension, bus timeout) and registers the branch
// decision. Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus and complete next cycle with a bus error.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      crt_mem_i,
  input  logic [1:0]      crt_wb_i,
  input  logic [2:0]      funct3_i,
  input  logic [31:0]     alu_result_i,
  input  logic [31:0]     dato_b_i,
  input  logic [31:0]     pc_next_i,
  input  logic            zero_i,
  input  logic [4:0]      inst_i,
  output logic            stall_o,
  output logic            branch_taken_o,
  output logic [31:0]     pc_target_o,
  mem_stage_lsu_if.master dmem,
  output logic            valid_o,
  output logic            reg_write_o,
  output logic [31:0]     wb_data_o,
  output logic [4:0]      inst_o,
  output logic            bus_err_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned BE_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;

  // EX/MEM register (held while the access is in flight)
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              rw_q;
  logic              m2r_q;
  logic [RD_W-1:0]   rd_q;
  logic              req_q;

  // MEM/WB register and branch outputs
  logic              valid_q;
  logic              reg_write_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [RD_W-1:0]   inst_q;
  logic              bus_err_q;
  logic              branch_taken_q;
  logic [XLEN-1:0]   pc_target_q;

  logic              is_mem_c;
  logic              misalign_c;

  // Byte enables from access size and low address bits; misaligned sizes fall back to
  // the natural lane (half uses a[1], word uses lane 0).
  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_be = BE_W'(4'b0001 << a);
      2'b01:   lane_be = BE_W'(4'b0011 << {a[1], 1'b0});
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so any byte enable picks the right bytes.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] b);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{b[7:0]}};
      2'b01:   lane_wdata = {2{b[15:0]}};
      default: lane_wdata = b;
    endcase
  endfunction

  // Pick the addressed byte/half lane of the read word and sign- or zero-extend it.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [XLEN-1:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = 8'(rdata >> {a, 3'b000});
    half_v = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_ext = f3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = rdata;
    endcase
  endfunction

  // Accepted instruction touches data memory (read, write or both).
  assign is_mem_c = crt_mem_i[0] | crt_mem_i[1];

  // Misalignment detection only exists in the trapping build.
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                      (funct3_i[1] && (alu_result_i[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Pipeline control FSM with EX/MEM, MEM/WB and bus output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      f3_q           <= '0;
      we_q           <= 1'b0;
      rw_q           <= 1'b0;
      m2r_q          <= 1'b0;
      rd_q           <= '0;
      req_q          <= 1'b0;
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      wb_data_q      <= '0;
      inst_q         <= '0;
      bus_err_q      <= 1'b0;
      branch_taken_q <= 1'b0;
      pc_target_q    <= '0;
    end else begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      bus_err_q      <= 1'b0;
      branch_taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            branch_taken_q <= crt_mem_i[2] & zero_i;
            pc_target_q    <= pc_next_i;
            if (!is_mem_c) begin
              valid_q     <= 1'b1;
              reg_write_q <= crt_wb_i[0];
              wb_data_q   <= alu_result_i;
              inst_q      <= inst_i;
            end else if (misalign_c) begin
              valid_q     <= 1'b1;
              bus_err_q   <= 1'b1;
              wb_data_q   <= alu_result_i;
              inst_q      <= inst_i;
            end else begin
              addr_q  <= alu_result_i;
              wdata_q <= lane_wdata(funct3_i, dato_b_i);
              be_q    <= lane_be(funct3_i, alu_result_i[1:0]);
              f3_q    <= funct3_i;
              we_q    <= crt_mem_i[1];
              rw_q    <= crt_wb_i[0];
              m2r_q   <= crt_wb_i[1];
              rd_q    <= inst_i;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem.ack) begin
            req_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            valid_q     <= 1'b1;
            reg_write_q <= rw_q & ~we_q;
            wb_data_q   <= (m2r_q && !we_q) ? load_ext(f3_q, addr_q[1:0], dmem.rdata) : addr_q;
            inst_q      <= rd_q;
          end else if (cnt_q == CNT_LAST) begin
            req_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            valid_q     <= 1'b1;
            bus_err_q   <= 1'b1;
            wb_data_q   <= addr_q;
            inst_q      <= rd_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus side: word-aligned address, everything else straight from the EX/MEM register.
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = {addr_q[31:2], 2'b00};
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  // Upstream freezes for exactly the cycles a request is outstanding.
  assign stall_o        = req_q;
  assign branch_taken_o = branch_taken_q;
  assign pc_target_o    = pc_target_q;
  assign valid_o        = valid_q;
  assign reg_write_o    = reg_write_q;
  assign wb_data_o      = wb_data_q;
  assign inst_o         = inst_q;
  assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: hand-derived vector table, hand sequences for reset and
// idle ACK, and randomized operations checked against a lane/extension arithmetic model.
module tb_mem_stage_lsu;

  localparam int unsigned TO = 4;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] b;
    logic [31:0] pc;
    logic        zero;
    logic [4:0]  rd;
    int          wait_cyc;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_rw;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [2:0]  crt_mem_i;
  logic [1:0]  crt_wb_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i;
  logic [31:0] dato_b_i;
  logic [31:0] pc_next_i;
  logic        zero_i;
  logic [4:0]  inst_i;
  logic        stall_o;
  logic        branch_taken_o;
  logic [31:0] pc_target_o;
  logic        valid_o;
  logic        reg_write_o;
  logic [31:0] wb_data_o;
  logic [4:0]  inst_o;
  logic        bus_err_o;

  int errors;
  int checks;

  mem_stage_lsu_if dmem_if();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .crt_mem_i      (crt_mem_i),
    .crt_wb_i       (crt_wb_i),
    .funct3_i       (funct3_i),
    .alu_result_i   (alu_result_i),
    .dato_b_i       (dato_b_i),
    .pc_next_i      (pc_next_i),
    .zero_i         (zero_i),
    .inst_i         (inst_i),
    .stall_o        (stall_o),
    .branch_taken_o (branch_taken_o),
    .pc_target_o    (pc_target_o),
    .dmem           (dmem_if),
    .valid_o        (valid_o),
    .reg_write_o    (reg_write_o),
    .wb_data_o      (wb_data_o),
    .inst_o         (inst_o),
    .bus_err_o      (bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] mem, logic [1:0] wb, logic [2:0] f3,
                              logic [31:0] alu, logic [31:0] b, logic [31:0] pc,
                              logic zero, logic [4:0] rd, int w, logic [31:0] rdata,
                              logic [3:0] be, logic [31:0] wdata, logic [31:0] wbd,
                              logic rw, logic err);
    vec_t v;
    v.mem = mem; v.wb = wb; v.f3 = f3; v.alu = alu; v.b = b; v.pc = pc; v.zero = zero;
    v.rd = rd; v.wait_cyc = w; v.rdata = rdata; v.exp_be = be; v.exp_wdata = wdata;
    v.exp_wb = wbd; v.exp_rw = rw; v.exp_err = err;
    return v;
  endfunction

  // Reference: access size in bytes, lane offset, masks and extension by plain arithmetic.
  function automatic vec_t model(vec_t v);
    vec_t        r;
    int          size;
    int          lane;
    logic [31:0] mask;
    logic [31:0] raw;
    bit          is_mem;
    bit          is_store;
    r = v;
    is_mem   = (v.mem[0] || v.mem[1]);
    is_store = v.mem[1];
    if (v.f3 % 4 == 0)      size = 1;
    else if (v.f3 % 4 == 1) size = 2;
    else                    size = 4;
    if (size == 1)      lane = int'(v.alu % 32'd4);
    else if (size == 2) lane = int'((v.alu % 32'd4) / 32'd2) * 2;
    else                lane = 0;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    r.exp_be = 4'(((1 << size) - 1) << lane);
    if (size == 1)      r.exp_wdata = (v.b & 32'hFF) * 32'h0101_0101;
    else if (size == 2) r.exp_wdata = (v.b & 32'hFFFF) * 32'h0001_0001;
    else                r.exp_wdata = v.b;
    raw = (v.rdata >> (8 * lane)) & mask;
    if (size < 4 && v.f3 < 3'd4 && raw >= ((mask + 32'd1) >> 1)) raw = raw | ~mask;
    r.exp_err = is_mem && (v.wait_cyc < 0 || v.wait_cyc >= int'(TO));
    r.exp_rw  = v.wb[0] && !r.exp_err && !(is_mem && is_store);
    r.exp_wb  = (is_mem && !is_store && v.wb[1]) ? raw : v.alu;
    return r;
  endfunction

  task automatic scramble();
    valid_i      = 1'b1;
    crt_mem_i    = 3'($urandom);
    crt_wb_i     = 2'($urandom);
    funct3_i     = 3'($urandom);
    alu_result_i = $urandom;
    dato_b_i     = $urandom;
    pc_next_i    = $urandom;
    zero_i       = 1'($urandom);
    inst_i       = 5'($urandom);
  endtask

  // Present one instruction, act as the memory, and check bus, latency and MEM/WB results.
  task automatic run_op(input vec_t v, input string name);
    int exp_req;
    int reqs;
    int cyc;
    bit is_mem;
    is_mem  = (v.mem[0] || v.mem[1]);
    exp_req = !is_mem ? 0 : ((v.wait_cyc < 0 || v.wait_cyc >= int'(TO)) ? int'(TO) : v.wait_cyc + 1);
    valid_i = 1'b1; crt_mem_i = v.mem; crt_wb_i = v.wb; funct3_i = v.f3;
    alu_result_i = v.alu; dato_b_i = v.b; pc_next_i = v.pc; zero_i = v.zero; inst_i = v.rd;
    @(posedge clk); #1;
    if (is_mem) scramble(); else valid_i = 1'b0;
    chk({name, ".branch"}, 32'(branch_taken_o), 32'(v.mem[2] & v.zero));
    chk({name, ".pc_target"}, pc_target_o, v.pc);
    reqs = 0;
    cyc  = 0;
    while (dmem_if.req === 1'b1 && cyc < MAX_WAIT) begin
      chk({name, ".stall"}, 32'(stall_o), 32'd1);
      chk({name, ".addr"}, dmem_if.addr, v.alu & 32'hFFFF_FFFC);
      chk({name, ".we"}, 32'(dmem_if.we), 32'(v.mem[1]));
      chk({name, ".be"}, 32'(dmem_if.be), 32'(v.exp_be));
      if (v.mem[1]) chk({name, ".wdata"}, dmem_if.wdata, v.exp_wdata);
      dmem_if.ack   = (cyc == v.wait_cyc) ? 1'b1 : 1'b0;
      dmem_if.rdata = dmem_if.ack ? v.rdata : $urandom;
      @(posedge clk); #1;
      dmem_if.ack = 1'b0;
      scramble();
      reqs++;
      cyc++;
    end
    valid_i = 1'b0;
    chk({name, ".req_cycles"}, 32'(reqs), 32'(exp_req));
    chk({name, ".valid"}, 32'(valid_o), 32'd1);
    chk({name, ".stall_end"}, 32'(stall_o), 32'd0);
    chk({name, ".bus_err"}, 32'(bus_err_o), 32'(v.exp_err));
    chk({name, ".reg_write"}, 32'(reg_write_o), 32'(v.exp_rw));
    chk({name, ".rd"}, 32'(inst_o), 32'(v.rd));
    if (!v.exp_err) chk({name, ".wb_data"}, wb_data_o, v.exp_wb);
    // One idle cycle, with a stray ACK now and then that must be ignored.
    dmem_if.ack = 1'($urandom);
    @(posedge clk); #1;
    dmem_if.ack = 1'b0;
    chk({name, ".idle_valid"}, 32'(valid_o), 32'd0);
    chk({name, ".idle_branch"}, 32'(branch_taken_o), 32'd0);
    chk({name, ".idle_req"}, 32'(dmem_if.req), 32'd0);
  endtask

  vec_t vec [17];
  vec_t rv;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    valid_i = 1'b0; crt_mem_i = '0; crt_wb_i = '0; funct3_i = '0; alu_result_i = '0;
    dato_b_i = '0; pc_next_i = '0; zero_i = 1'b0; inst_i = '0;
    dmem_if.ack = 1'b0; dmem_if.rdata = '0;

    //          mem     wb     f3      alu           b             pc         z     rd  w   rdata          be       wdata          wb_data       rw    err
    vec[0]  = mk(3'b000, 2'b01, 3'b000, 32'h1234,     32'h0,        32'h0,     1'b0, 5,  0, 32'h0,         4'b0000, 32'h0,         32'h1234,     1'b1, 1'b0);
    vec[1]  = mk(3'b010, 2'b00, 3'b000, 32'h103,      32'hAB,       32'h0,     1'b0, 6,  3, 32'h0,         4'b1000, 32'hABABABAB,  32'h103,      1'b0, 1'b0);
    vec[2]  = mk(3'b001, 2'b11, 3'b000, 32'h101,      32'h0,        32'h0,     1'b0, 7,  0, 32'h0000_8000, 4'b0010, 32'h0,         32'hFFFFFF80, 1'b1, 1'b0);
    vec[3]  = mk(3'b001, 2'b11, 3'b100, 32'h101,      32'h0,        32'h0,     1'b0, 8,  0, 32'h0000_8000, 4'b0010, 32'h0,         32'h00000080, 1'b1, 1'b0);
    vec[4]  = mk(3'b001, 2'b11, 3'b010, 32'h200,      32'h0,        32'h0,     1'b0, 9, -1, 32'h0,         4'b1111, 32'h0,         32'h0,        1'b0, 1'b1);
    vec[5]  = mk(3'b100, 2'b00, 3'b000, 32'h0,        32'h0,        32'h40,    1'b1, 0,  0, 32'h0,         4'b0000, 32'h0,         32'h0,        1'b0, 1'b0);
    vec[6]  = mk(3'b100, 2'b00, 3'b000, 32'h0,        32'h0,        32'h44,    1'b0, 0,  0, 32'h0,         4'b0000, 32'h0,         32'h0,        1'b0, 1'b0);
    vec[7]  = mk(3'b010, 2'b01, 3'b001, 32'h102,      32'h12345678, 32'h0,     1'b0, 10, 1, 32'h0,         4'b1100, 32'h56785678,  32'h102,      1'b0, 1'b0);
    vec[8]  = mk(3'b001, 2'b11, 3'b001, 32'h102,      32'h0,        32'h0,     1'b0, 11, 2, 32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF8001, 1'b1, 1'b0);
    vec[9]  = mk(3'b001, 2'b11, 3'b101, 32'h100,      32'h0,        32'h0,     1'b0, 12, 0, 32'h1234_F00D, 4'b0011, 32'h0,         32'h0000F00D, 1'b1, 1'b0);
    vec[10] = mk(3'b001, 2'b11, 3'b010, 32'h203,      32'h0,        32'h0,     1'b0, 13, 1, 32'hDEADBEEF,  4'b1111, 32'h0,         32'hDEADBEEF, 1'b1, 1'b0);
    vec[11] = mk(3'b001, 2'b11, 3'b001, 32'h103,      32'h0,        32'h0,     1'b0, 14, 0, 32'h7FFF_0000, 4'b1100, 32'h0,         32'h00007FFF, 1'b1, 1'b0);
    vec[12] = mk(3'b010, 2'b00, 3'b011, 32'h300,      32'hCAFEF00D, 32'h0,     1'b0, 15, 0, 32'h0,         4'b1111, 32'hCAFEF00D,  32'h300,      1'b0, 1'b0);
    vec[13] = mk(3'b011, 2'b01, 3'b010, 32'h304,      32'h01020304, 32'h0,     1'b0, 16, 0, 32'hFFFF_FFFF, 4'b1111, 32'h01020304,  32'h304,      1'b0, 1'b0);
    vec[14] = mk(3'b001, 2'b11, 3'b010, 32'h400,      32'h0,        32'h0,     1'b0, 17, 3, 32'h11223344,  4'b1111, 32'h0,         32'h11223344, 1'b1, 1'b0);
    vec[15] = mk(3'b001, 2'b01, 3'b010, 32'h404,      32'h0,        32'h0,     1'b0, 18, 0, 32'h55555555,  4'b1111, 32'h0,         32'h404,      1'b1, 1'b0);
    vec[16] = mk(3'b110, 2'b00, 3'b000, 32'h0,        32'h5A,       32'h80,    1'b1, 19, 0, 32'h0,         4'b0001, 32'h5A5A5A5A,  32'h0,        1'b0, 1'b0);

    // Reset state.
    @(posedge clk); #1;
    chk("reset.req", 32'(dmem_if.req), 32'd0);
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.valid", 32'(valid_o), 32'd0);
    chk("reset.branch", 32'(branch_taken_o), 32'd0);
    chk("reset.pc_target", pc_target_o, 32'd0);
    chk("reset.wb_data", wb_data_o, 32'd0);
    chk("reset.bus_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_op(vec[i], $sformatf("vec%0d", i));

    // Reset in the middle of an outstanding load abandons it.
    valid_i = 1'b1; crt_mem_i = 3'b001; crt_wb_i = 2'b11; funct3_i = 3'b010;
    alu_result_i = 32'h500; inst_i = 5'd20;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("rstmid.req_before", 32'(dmem_if.req), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rstmid.req_drop", 32'(dmem_if.req), 32'd0);
    chk("rstmid.stall_drop", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_if.ack = 1'b1;
    @(posedge clk); #1;
    dmem_if.ack = 1'b0;
    chk("rstmid.no_valid", 32'(valid_o), 32'd0);
    chk("rstmid.idle_req", 32'(dmem_if.req), 32'd0);
    run_op(mk(3'b001, 2'b11, 3'b010, 32'h504, 32'h0, 32'h0, 1'b0, 5'd21, 1, 32'hA5A5_0F0F,
              4'b1111, 32'h0, 32'hA5A5_0F0F, 1'b1, 1'b0), "rstmid.next_lw");

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      rv.mem = 3'($urandom); rv.wb = 2'($urandom); rv.f3 = 3'($urandom);
      rv.alu = $urandom; rv.b = $urandom; rv.pc = $urandom; rv.zero = 1'($urandom);
      rv.rd = 5'($urandom); rv.rdata = $urandom;
      rv.wait_cyc = int'($urandom_range(0, 5));
      if (rv.wait_cyc == 5) rv.wait_cyc = -1;
      rv = model(rv);
      run_op(rv, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
